alu_result_display: RTL and testbench
=====================================

Name: alu_result_display

Overview:
- Downstream consumer of the 5-bit ALU datapath top level.
- Captures Result and ALUFlags on a load strobe and converts the captured result to decimal.
- Time-multiplexes four common-anode 7-segment digits: sign, tens, ones, flags nibble as hex.
- Sits between the ALU top level and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays enabled (must be >= 2).
- SIGNED_MODE, 1, 1 = interpret the 5-bit result as two's complement; 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; capture result/flags this edge.
- result  input  5  ALU Result.
- alu_flags  input  4  ALU flags {N,Z,C,V}.
- an  output  4  digit enables, active low; an[3] is the leftmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.

Behaviour:
- Reset is asynchronous on rst_n low; it acts immediately, mid-scan or mid-load.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, captured result=0, captured flags=0, refresh counter=0, digit index=0.
- Capture: on a clk edge with load=1, the captured registers take result/alu_flags. The display reflects the new values on the next edge (1-cycle latency). A load asserted on consecutive cycles keeps the last value.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap, the digit index increments modulo 4 (3->0). Digit index sequence: 0,1,2,3,0…
- Outputs an/seg/dp are registered from digit index and captured values; one-cycle pipeline.
  - an = one-hot low of index (index 0 -> 4'b1110).
  - The first edge after reset release drives an=4'b1110.
- Digit 0 (rightmost): hex glyph of captured flags 0..F. dp=0 when flag V=1, else dp=1.
- Digit 1: ones of magnitude.
- Digit 2: tens of magnitude, 0..3.
- Digit 3:
  - In SIGNED_MODE=1, shows '-' (seg=7'b0111111) when captured result[4]=1, else blank (7'b1111111).
  - In SIGNED_MODE=0, always blank.
- dp=1 on digits 1..3.
- Magnitude:
  - SIGNED_MODE=1: negative values are two's complement negated into 5 bits, so -16 gives magnitude 16.
  - SIGNED_MODE=0: raw 0..31.
  - tens = mag/10, ones = mag%10, computed combinationally on 5 bits, no clamping.
- Glyphs: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000, A=7'b0001000, b=7'b0000011, C=7'b1000110, d=7'b0100001, E=7'b0000110, F=7'b0001110.
- Simultaneous load and counter wrap: the digit advances and the capture takes effect; the next edge shows the new digit with the new data.
- No state machine beyond the 2-bit index; there are no illegal states.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digit 2 is blanked (7'b1111111) when tens=0.
- Not defined: digit 2 always shows its glyph, including '0'.
- Everything else is identical in both builds.

Test Plan:
- Reset release with REFRESH_DIV=4:
  - an=4'b1110 on the first edge after release.
  - an steps 1101, 1011, 0111 every 4 cycles, then wraps to 1110.
  - seg on digit 0 = '0' glyph.
- SIGNED_MODE=1, load result=5'b10110 (-10), flags=4'b1000:
  - digit 3 = '-', digit 2 = '1', digit 1 = '0'.
  - digit 0 = '8' glyph, dp=1.
- SIGNED_MODE=1, result=5'b10000, flags=4'b0001:
  - digits show '-', '1', '6', '1'.
  - dp=0 only while an=4'b1110.
- SIGNED_MODE=0, result=5'b11111, flags=4'b0110:
  - digit 3 blank, digits '3', '1', '6'.
- Load 5'b00011, then assert rst_n=0 mid-scan:
  - an=4'b1111 and seg=7'b1111111 immediately, without waiting for a clock edge.
  - After release, digit 1 shows '0' (the captured value was cleared).
- LEADING_ZERO_BLANK_EN defined, result=5'b00111:
  - digit 2 blank, digit 1 = '7'.
  - Without the macro, digit 2 = '0'.

Source files
------------

// File: rtl/alu_result_display.sv
// Captures the ALU result and flags on a load strobe and scans them onto four
// common-anode 7-segment digits. Optional build macro: LEADING_ZERO_BLANK_EN.
module alu_result_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          SIGNED_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] result,
    input  logic [3:0] alu_flags,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        DIG_FLAGS = 2'd0,
        DIG_ONES  = 2'd1,
        DIG_TENS  = 2'd2,
        DIG_SIGN  = 2'd3
    } digit_e;

    logic [4:0]       r_result;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_cnt;
    digit_e           r_idx;

    logic [4:0]       w_mag;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;
    logic             w_neg;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // -16 negates to itself in 5 bits, which reads back as magnitude 16 unsigned.
    assign w_neg  = SIGNED_MODE && r_result[4];
    assign w_mag  = w_neg ? (5'd0 - r_result) : r_result;
    assign w_tens = 4'(w_mag / 5'd10);
    assign w_ones = 4'(w_mag % 5'd10);

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        case (r_idx)
            DIG_FLAGS: begin
                w_an_nxt  = 4'b1110;
                w_seg_nxt = hex_glyph(r_flags);
                w_dp_nxt  = ~r_flags[0];
            end
            DIG_ONES: begin
                w_an_nxt  = 4'b1101;
                w_seg_nxt = hex_glyph(w_ones);
            end
            DIG_TENS: begin
                w_an_nxt  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                w_seg_nxt = (w_tens == 4'd0) ? SEG_BLANK : hex_glyph(w_tens);
`else
                w_seg_nxt = hex_glyph(w_tens);
`endif
            end
            default: begin
                w_an_nxt  = 4'b0111;
                w_seg_nxt = w_neg ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
            r_cnt    <= '0;
            r_idx    <= DIG_FLAGS;
            an       <= '1;
            seg      <= '1;
            dp       <= 1'b1;
        end else begin
            if (load) begin
                r_result <= result;
                r_flags  <= alu_flags;
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= digit_e'(r_idx + 2'd1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
            dp  <= w_dp_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: a signed and an unsigned instance
// checked against an arithmetic model of the display scan.
module tb_alu_result_display;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [4:0] result;
    logic [3:0] alu_flags;
    logic [3:0] an_s, an_u;
    logic [6:0] seg_s, seg_u;
    logic       dp_s, dp_u;

    alu_result_display #(.REFRESH_DIV(DIV), .SIGNED_MODE(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .load(load), .result(result),
        .alu_flags(alu_flags), .an(an_s), .seg(seg_s), .dp(dp_s)
    );

    alu_result_display #(.REFRESH_DIV(DIV), .SIGNED_MODE(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .load(load), .result(result),
        .alu_flags(alu_flags), .an(an_u), .seg(seg_u), .dp(dp_u)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    typedef struct packed {
        disp_t s;
        disp_t u;
    } exp_t;

    logic [6:0] glyph_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t q[$];
    exp_t e_push, e_pop;
    int   cycles, cap_res, cap_flags;
    int   total = 0;
    int   bad   = 0;

    function automatic disp_t model(input int digit, input int res, input int flags, input bit sgn);
        disp_t d;
        int    value, mag;
        value      = (sgn && res >= 16) ? res - 32 : res;
        mag        = (value < 0) ? -value : value;
        d.an       = 4'b1111;
        d.an[digit] = 1'b0;
        d.dp       = 1'b1;
        d.seg      = 7'b1111111;
        case (digit)
            0: begin
                d.seg = glyph_tab[flags];
                d.dp  = (flags % 2 == 1) ? 1'b0 : 1'b1;
            end
            1: d.seg = glyph_tab[mag % 10];
            2: begin
                d.seg = glyph_tab[mag / 10];
`ifdef LEADING_ZERO_BLANK_EN
                if (mag / 10 == 0) d.seg = 7'b1111111;
`endif
            end
            default: d.seg = (value < 0) ? 7'b0111111 : 7'b1111111;
        endcase
        return d;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: digit follows elapsed cycles since reset, capture is the last load.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles    = 0;
            cap_res   = 0;
            cap_flags = 0;
            q.delete();
        end else begin
            e_push.s = model((cycles / DIV) % 4, cap_res, cap_flags, 1'b1);
            e_push.u = model((cycles / DIV) % 4, cap_res, cap_flags, 1'b0);
            q.push_back(e_push);
            cycles++;
            if (load) begin
                cap_res   = int'(result);
                cap_flags = int'(alu_flags);
            end
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_pop = q.pop_front();
            check("an_signed",    int'(an_s),  int'(e_pop.s.an));
            check("seg_signed",   int'(seg_s), int'(e_pop.s.seg));
            check("dp_signed",    int'(dp_s),  int'(e_pop.s.dp));
            check("an_unsigned",  int'(an_u),  int'(e_pop.u.an));
            check("seg_unsigned", int'(seg_u), int'(e_pop.u.seg));
            check("dp_unsigned",  int'(dp_u),  int'(e_pop.u.dp));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an_s"},  int'(an_s),  'hF);
        check({tag, "_seg_s"}, int'(seg_s), 'h7F);
        check({tag, "_dp_s"},  int'(dp_s),  1);
        check({tag, "_an_u"},  int'(an_u),  'hF);
        check({tag, "_seg_u"}, int'(seg_u), 'h7F);
        check({tag, "_dp_u"},  int'(dp_u),  1);
    endtask

    task automatic do_load(input logic [4:0] r, input logic [3:0] f, input int hold);
        @(negedge clk);
        load      = 1'b1;
        result    = r;
        alu_flags = f;
        @(negedge clk);
        load      = 1'b0;
        result    = 5'(~r);
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        result    = '0;
        alu_flags = '0;
        #7;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        do_load(5'b10110, 4'b1000, 20);
        do_load(5'b10000, 4'b0001, 20);
        do_load(5'b11111, 4'b0110, 20);
        do_load(5'b00111, 4'b0000, 20);

        // Back-to-back loads: the second value must win.
        @(negedge clk);
        load = 1'b1; result = 5'b01001; alu_flags = 4'b1111;
        @(negedge clk);
        result = 5'b11010; alu_flags = 4'b0011;
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);

        do_load(5'b00011, 4'b0101, 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midscan");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (24) @(negedge clk);

        repeat (600) begin
            @(negedge clk);
            load      = ($urandom_range(0, 4) == 0);
            result    = 5'($urandom);
            alu_flags = 4'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
